clock_time_controller: RTL and testbench

Sequencer for the hours/minutes/seconds wrap-around up/down counters of the clock datapath. In RUN mode it converts the 1 Hz tick into cascaded increment commands. In SET modes it routes debounced inc/dec button pulses to one selected field. It sits between the button/tick front end and the three counter instances and owns every counter's `{up, down}` command pins.

---
 rtl/clock_ctrl_pkg.sv | 41 ++++
 rtl/clock_set_timeout.sv | 52 +++++
 rtl/clock_time_controller.sv | 138 +++++++++++++
 tb/tb_clock_time_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// ============================================================================
// clock_ctrl_pkg : states, field codes and counter commands of the clock controller
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_SEC  = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_HOUR = 2'b11;

  // Counter {up, down} command encodings
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  function automatic logic [1:0] state_field(input state_t s);
    logic [1:0] f;
    f = FIELD_NONE;
    case (s)
      SET_HOUR: f = FIELD_HOUR;
      SET_MIN:  f = FIELD_MIN;
      SET_SEC:  f = FIELD_SEC;
      default:  f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_set_timeout.sv
// ============================================================================
// clock_set_timeout : idle-tick counter for SET-mode timeout and blink phase
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_set_timeout #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_set,
  input  logic tick,
  input  logic activity,
  output logic expire,
  output logic blink
);

  localparam logic [7:0] c_limit = 8'(TIMEOUT_TICKS);

  logic [7:0] r_idle;
  logic       r_blink;

  // The count saturates at the limit; it is only non-zero while a SET state is held
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle <= '0;
    end else if (!in_set || activity) begin
      r_idle <= '0;
    end else if (tick && (r_idle != c_limit)) begin
      r_idle <= r_idle + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blink <= 1'b0;
    end else if (!in_set) begin
      r_blink <= 1'b0;
    end else if (activity) begin
      r_blink <= 1'b1;
    end else if (tick) begin
      r_blink <= ~r_blink;
    end
  end

  assign expire = (r_idle == c_limit);
  assign blink  = r_blink;

endmodule

`default_nettype wire

// File: rtl/clock_time_controller.sv
// ============================================================================
// clock_time_controller : RUN/SET sequencer driving the h/m/s counter commands
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_time_controller
  import clock_ctrl_pkg::*;
#(
  parameter int SEC_MAX       = 59,
  parameter int MIN_MAX       = 59,
  parameter int HOUR_MAX      = 23,
  parameter int HOUR_W        = 5,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_tick,
  input  logic              i_mode,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic [5:0]        i_sec,
  input  logic [5:0]        i_min,
  input  logic [HOUR_W-1:0] i_hour,
  output logic              o_sec_up,
  output logic              o_sec_down,
  output logic              o_min_up,
  output logic              o_min_down,
  output logic              o_hour_up,
  output logic              o_hour_down,
  output logic [1:0]        o_field,
  output logic              o_setting,
  output logic              o_blink
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_tick_issued;
  logic       w_run_tick;
  logic       w_btn;
  logic       w_expire;
  logic       w_activity;
  logic [1:0] w_set_cmd;
  logic [1:0] w_sec_cmd;
  logic [1:0] w_min_cmd;
  logic [1:0] w_hour_cmd;

  // Hour wrap is handled inside the hour counter itself
  logic w_unused_hour;
  assign w_unused_hour = ^{i_hour, HOUR_W'(HOUR_MAX)};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sec_cmd    = HOLD;
    w_min_cmd    = HOLD;
    w_hour_cmd   = HOLD;
    w_set_cmd    = HOLD;

    // A tick right after an issued tick sees stale counter values
    w_run_tick = (r_state == RUN) && i_tick && !r_tick_issued;
    w_btn      = (r_state != RUN) && !i_mode && (i_inc || i_dec);

    if (i_inc && i_dec)  w_set_cmd = CLR;
    else if (i_inc)      w_set_cmd = UP;
    else if (i_dec)      w_set_cmd = DOWN;

    if (w_run_tick) begin
      w_sec_cmd = UP;
      if (i_sec == 6'(SEC_MAX)) begin
        w_min_cmd = UP;
        if (i_min == 6'(MIN_MAX)) w_hour_cmd = UP;
      end
    end

    if (w_btn) begin
      case (r_state)
        SET_HOUR: w_hour_cmd = w_set_cmd;
        SET_MIN:  w_min_cmd  = w_set_cmd;
        SET_SEC:  w_sec_cmd  = w_set_cmd;
        default:  ;
      endcase
    end

    if ((r_state != RUN) && w_expire) begin
      w_next_state = RUN;
    end else if (i_mode) begin
      case (r_state)
        RUN:      w_next_state = SET_HOUR;
        SET_HOUR: w_next_state = SET_MIN;
        SET_MIN:  w_next_state = SET_SEC;
        default:  w_next_state = RUN;
      endcase
    end
  end

  assign w_activity = i_mode || i_inc || i_dec;

  clock_set_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .in_set   (w_next_state != RUN),
    .tick     (i_tick),
    .activity (w_activity),
    .expire   (w_expire),
    .blink    (o_blink)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      {o_sec_up,  o_sec_down}  <= HOLD;
      {o_min_up,  o_min_down}  <= HOLD;
      {o_hour_up, o_hour_down} <= HOLD;
      o_field                  <= FIELD_NONE;
      o_setting                <= 1'b0;
      r_tick_issued            <= 1'b0;
    end else begin
      {o_sec_up,  o_sec_down}  <= w_sec_cmd;
      {o_min_up,  o_min_down}  <= w_min_cmd;
      {o_hour_up, o_hour_down} <= w_hour_cmd;
      o_field                  <= state_field(w_next_state);
      o_setting                <= (w_next_state != RUN);
      r_tick_issued            <= w_run_tick;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_time_controller.sv
// ============================================================================
// tb_clock_time_controller : scoreboard bench for clock_time_controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_time_controller;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic       mode = 1'b0;
  logic       inc  = 1'b0;
  logic       dec  = 1'b0;
  logic [5:0] sec  = 6'd0;
  logic [5:0] min  = 6'd0;
  logic [4:0] hour = 5'd0;

  logic       sec_up, sec_down, min_up, min_down, hour_up, hour_down;
  logic [1:0] field;
  logic       setting, blink;
  logic [5:0] cmd;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q[$];

  // Command vector order: sec_up sec_down min_up min_down hour_up hour_down
  assign cmd = {sec_up, sec_down, min_up, min_down, hour_up, hour_down};

  always #5 clk = ~clk;

  clock_time_controller #(
    .SEC_MAX       (59),
    .MIN_MAX       (59),
    .HOUR_MAX      (23),
    .HOUR_W        (5),
    .TIMEOUT_TICKS (10)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_tick      (tick),
    .i_mode      (mode),
    .i_inc       (inc),
    .i_dec       (dec),
    .i_sec       (sec),
    .i_min       (min),
    .i_hour      (hour),
    .o_sec_up    (sec_up),
    .o_sec_down  (sec_down),
    .o_min_up    (min_up),
    .o_min_down  (min_down),
    .o_hour_up   (hour_up),
    .o_hour_down (hour_down),
    .o_field     (field),
    .o_setting   (setting),
    .o_blink     (blink)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented command pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rstn && (cmd != 6'd0)) begin
      if (exp_q.size() == 0) check("unexpected_cmd", {2'b00, cmd}, 8'd0);
      else                   check("cmd", {2'b00, cmd}, {2'b00, exp_q.pop_front()});
    end
  end

  // One event cycle followed by one idle cycle; returns #1 after the idle edge
  task automatic ev(input logic m, input logic i, input logic d, input logic t,
                    input bit push, input logic [5:0] exp);
    mode = m; inc = i; dec = d; tick = t;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    mode = 1'b0; inc = 1'b0; dec = 1'b0; tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_status(input string name, input logic [1:0] f, input logic s);
    check({name, "_field"}, {6'd0, field}, {6'd0, f});
    check({name, "_setting"}, {7'd0, setting}, {7'd0, s});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd", {2'b00, cmd}, 8'd0);
    check_status("rst", 2'b00, 1'b0);
    check("rst_blink", {7'd0, blink}, 8'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // RUN: plain tick, partial cascade, full cascade
    sec = 6'd10; min = 6'd0; hour = 5'd0;
    ev(0, 0, 0, 1, 1, 6'b100000);
    sec = 6'd59; min = 6'd10;
    ev(0, 0, 0, 1, 1, 6'b101000);
    sec = 6'd59; min = 6'd59; hour = 5'd23;
    ev(0, 0, 0, 1, 1, 6'b101010);
    ev(0, 1, 1, 0, 0, 6'b000000);
    check_status("run_btn", 2'b00, 1'b0);

    // Mode with tick in RUN: tick honoured, enter SET_HOUR
    sec = 6'd10; min = 6'd0;
    ev(1, 0, 0, 1, 1, 6'b100000);
    check_status("set_hour", 2'b11, 1'b1);
    ev(0, 1, 0, 0, 1, 6'b000010);
    ev(0, 1, 0, 0, 1, 6'b000010);
    check("blink_after_inc", {7'd0, blink}, 8'd1);
    ev(0, 0, 0, 1, 0, 6'b000000);
    check("blink_toggle", {7'd0, blink}, 8'd0);
    ev(0, 1, 0, 0, 1, 6'b000010);
    check("blink_after_inc2", {7'd0, blink}, 8'd1);
    ev(0, 0, 1, 0, 1, 6'b000001);
    check_status("set_hour_end", 2'b11, 1'b1);

    // SET_MIN: clear, then mode together with inc
    ev(1, 0, 0, 0, 0, 6'b000000);
    check_status("set_min", 2'b10, 1'b1);
    ev(0, 1, 1, 0, 1, 6'b001100);
    ev(1, 1, 0, 0, 0, 6'b000000);
    check_status("set_sec", 2'b01, 1'b1);

    // SET_SEC idle timeout
    sec = 6'd30;
    for (int k = 0; k < 9; k++) ev(0, 0, 0, 1, 0, 6'b000000);
    check_status("before_timeout", 2'b01, 1'b1);
    ev(0, 0, 0, 1, 0, 6'b000000);
    check_status("after_timeout", 2'b00, 1'b0);
    check("timeout_blink", {7'd0, blink}, 8'd0);
    sec = 6'd10;
    ev(0, 0, 0, 1, 1, 6'b100000);

    // Reset while a SET_MIN command pulse is high
    ev(1, 0, 0, 0, 0, 6'b000000);
    ev(1, 0, 0, 0, 0, 6'b000000);
    check_status("pre_rst", 2'b10, 1'b1);
    inc = 1'b1;
    @(posedge clk); #1;
    inc = 1'b0;
    #1;
    check("pulse_before_rst", {2'b00, cmd}, 8'b00001000);
    rstn = 1'b0;
    #1;
    check("async_rst_cmd", {2'b00, cmd}, 8'd0);
    check_status("async_rst", 2'b00, 1'b0);
    check("async_rst_blink", {7'd0, blink}, 8'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check_status("post_rst", 2'b00, 1'b0);
    ev(0, 0, 0, 1, 1, 6'b100000);

    repeat (3) @(posedge clk);
    #1;
    check("pending_expectations", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
